// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch-stage control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAIT,
    ST_REDIRECT,
    ST_ERROR
  } fetch_state_t;

  // ctrlMux1 encodings: sequential PC or writeback result
  localparam logic PCSRC_PLUS4  = 1'b0;
  localparam logic PCSRC_RESULT = 1'b1;
  // ctrlMux2 encodings: pass mux1 output or take branch target
  localparam logic PCSRC_SEQ    = 1'b0;
  localparam logic PCSRC_BRANCH = 1'b1;

  localparam int DEF_BOOT_CYCLES = 2;
  localparam int DEF_MAX_WAIT    = 15;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency: count reflects inc one cycle after it is sampled.
// Backpressure: none; inc is ignored once saturated.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // clear wins over increment; stop at the maximum instead of wrapping
  always_ff @(posedge clock) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: PC/IF-ID enables, PC-source selects, imem handshake.
// Latency: enables and mux selects are combinational from state and inputs.
// Backpressure: stallD holds PC and IF/ID; a missing imemReady inserts bubbles.
module fetch_sequencer
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = DEF_BOOT_CYCLES,
  parameter int MAX_WAIT    = DEF_MAX_WAIT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             imemReady,
  input  logic             pcWriteW,
  input  logic             branchTakenE,
  input  logic             stallD,
  output logic             imemReq,
  output logic             pcEnable,
  output logic             pipeEnable,
  output logic             clearPipe,
  output logic             ctrlMux1,
  output logic             ctrlMux2,
  output logic             fetchError,
  output logic [CNT_W-1:0] stallCount
);

  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  fetch_state_t      state, stateNext;
  logic [BOOT_W-1:0] bootCnt, bootCntNext;
  logic [WAIT_W-1:0] waitCnt, waitCntNext;
  logic              redirect;
  logic              stallInc;

  // state and inline counters; reset returns to BOOT from anywhere
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_BOOT;
      bootCnt <= '0;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      bootCnt <= bootCntNext;
      waitCnt <= waitCntNext;
    end
  end

  // next state and all outputs; defaults describe a frozen PC with a bubble
  always_comb begin
    stateNext   = state;
    bootCntNext = bootCnt;
    waitCntNext = waitCnt;
    imemReq     = 1'b0;
    pcEnable    = 1'b0;
    pipeEnable  = 1'b1;
    clearPipe   = 1'b1;
    ctrlMux1    = PCSRC_PLUS4;
    ctrlMux2    = PCSRC_SEQ;
    fetchError  = 1'b0;
    stallInc    = 1'b0;
    redirect    = pcWriteW || branchTakenE;

    case (state)
      ST_BOOT: begin
        if (bootCnt == BOOT_W'(BOOT_CYCLES - 1)) begin
          stateNext = ST_RUN;
        end else begin
          bootCntNext = bootCnt + 1'b1;
        end
      end

      ST_RUN, ST_WAIT: begin
        imemReq  = 1'b1;
        stallInc = 1'b1;
        if (redirect) begin
          // writeback redirect beats a branch; the branch is simply dropped
          pcEnable  = 1'b1;
          stallInc  = 1'b0;
          ctrlMux1  = pcWriteW ? PCSRC_RESULT : PCSRC_PLUS4;
          ctrlMux2  = (branchTakenE && !pcWriteW) ? PCSRC_BRANCH : PCSRC_SEQ;
          stateNext = ST_REDIRECT;
        end else if (stallD) begin
          pipeEnable = 1'b0;
          clearPipe  = 1'b0;
          // an outstanding miss keeps timing out even while decode stalls
          if (state == ST_WAIT) begin
            if (imemReady) begin
              stateNext = ST_RUN;
            end else if (waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
              stateNext = ST_ERROR;
            end else begin
              waitCntNext = waitCnt + 1'b1;
            end
          end
        end else if (imemReady) begin
          pcEnable  = 1'b1;
          clearPipe = 1'b0;
          stallInc  = 1'b0;
          stateNext = ST_RUN;
        end else if (state == ST_RUN) begin
          stateNext   = ST_WAIT;
          waitCntNext = WAIT_W'(1);
        end else if (waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
          stateNext = ST_ERROR;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
      end

      ST_REDIRECT: begin
        // imemReq low drops whatever fetch was in flight for the old path
        if (redirect) begin
          pcEnable = 1'b1;
          ctrlMux1 = pcWriteW ? PCSRC_RESULT : PCSRC_PLUS4;
          ctrlMux2 = (branchTakenE && !pcWriteW) ? PCSRC_BRANCH : PCSRC_SEQ;
        end else begin
          stateNext = ST_RUN;
        end
      end

      ST_ERROR: begin
        fetchError = 1'b1;
      end

      default: begin
        stateNext = ST_BOOT;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clock (clock),
    .clr   (reset),
    .inc   (stallInc),
    .count (stallCount)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table, hand sequences, random vs model.
// Latency: outputs sampled on the falling edge, state advanced on the rising edge.
// Backpressure: n/a.
module tb_fetch_sequencer;

  localparam int BOOT = 2;
  localparam int MAXW = 15;

  logic        clock = 1'b0;
  logic        reset, imemReady, pcWriteW, branchTakenE, stallD;
  logic        imemReq, pcEnable, pipeEnable, clearPipe, ctrlMux1, ctrlMux2, fetchError;
  logic [15:0] stallCount;
  logic        imemReq3, pcEnable3, pipeEnable3, clearPipe3, ctrlMux13, ctrlMux23, fetchError3;
  logic [2:0]  stallCount3;

  int vectors = 0;
  int miscompares = 0;

  // reference model state: remaining boot cycles, consecutive misses, flags
  int       mBoot, mMiss, mStalls;
  bit       mErr, mRedir;
  logic [6:0] mVec;

  typedef struct packed {
    logic        rst, rdy, pcw, br, stall;
    logic [6:0]  exp;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[$];

  always #5 clock = ~clock;

  fetch_sequencer #(.BOOT_CYCLES(BOOT), .MAX_WAIT(MAXW), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .imemReady(imemReady), .pcWriteW(pcWriteW),
    .branchTakenE(branchTakenE), .stallD(stallD), .imemReq(imemReq),
    .pcEnable(pcEnable), .pipeEnable(pipeEnable), .clearPipe(clearPipe),
    .ctrlMux1(ctrlMux1), .ctrlMux2(ctrlMux2), .fetchError(fetchError),
    .stallCount(stallCount)
  );

  // narrow counter copy to exercise saturation within a short run
  fetch_sequencer #(.BOOT_CYCLES(BOOT), .MAX_WAIT(MAXW), .CNT_W(3)) dut3 (
    .clock(clock), .reset(reset), .imemReady(imemReady), .pcWriteW(pcWriteW),
    .branchTakenE(branchTakenE), .stallD(stallD), .imemReq(imemReq3),
    .pcEnable(pcEnable3), .pipeEnable(pipeEnable3), .clearPipe(clearPipe3),
    .ctrlMux1(ctrlMux13), .ctrlMux2(ctrlMux23), .fetchError(fetchError3),
    .stallCount(stallCount3)
  );

  function automatic logic [6:0] actVec();
    return {imemReq, pcEnable, pipeEnable, clearPipe, ctrlMux1, ctrlMux2, fetchError};
  endfunction

  function automatic logic [6:0] actVec3();
    return {imemReq3, pcEnable3, pipeEnable3, clearPipe3, ctrlMux13, ctrlMux23, fetchError3};
  endfunction

  function automatic int sat3(input int c);
    return (c > 7) ? 7 : c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic pw, input logic b, input logic s);
    reset = r; imemReady = rd; pcWriteW = pw; branchTakenE = b; stallD = s;
  endtask

  // expected outputs from the fetch-stage rules for the current inputs
  task automatic modelEval();
    logic req, pe, pipe, clr, m1, m2, err, redir;
    req = 0; pe = 0; pipe = 1; clr = 1; m1 = 0; m2 = 0; err = 0;
    redir = pcWriteW || branchTakenE;
    if (mErr) begin
      err = 1;
    end else if (mBoot > 0) begin
      // frozen, IF/ID cleared, redirects ignored
    end else begin
      req = !mRedir;
      if (redir) begin
        pe = 1; m1 = pcWriteW; m2 = branchTakenE && !pcWriteW;
      end else if (!mRedir) begin
        if (stallD) begin
          pipe = 0; clr = 0;
        end else if (imemReady) begin
          pe = 1; clr = 0;
        end
      end
    end
    mVec = {req, pe, pipe, clr, m1, m2, err};
  endtask

  task automatic modelStep();
    bit redir;
    redir = pcWriteW || branchTakenE;
    if (reset) begin
      mBoot = BOOT; mErr = 0; mRedir = 0; mMiss = 0; mStalls = 0;
    end else if (mErr) begin
    end else if (mBoot > 0) begin
      mBoot--;
    end else if (mRedir) begin
      mRedir = redir;
    end else begin
      if (!mVec[5] && mStalls < 65535) mStalls++;
      if (redir) begin
        mRedir = 1; mMiss = 0;
      end else if (imemReady) begin
        mMiss = 0;
      end else if (!(stallD && mMiss == 0)) begin
        mMiss++;
        if (mMiss >= MAXW) mErr = 1;
      end
    end
  endtask

  task automatic tick();
    modelEval();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic addv(input logic r, input logic rd, input logic pw, input logic b,
                      input logic s, input logic [6:0] e, input int c);
    vec_t v;
    v.rst = r; v.rdy = rd; v.pcw = pw; v.br = b; v.stall = s; v.exp = e; v.cnt = 16'(c);
    tbl.push_back(v);
  endtask

  initial begin
    int burst;
    // output order: req pcEn pipeEn clear mux1 mux2 err
    addv(0,1,0,0,0, 7'b0011000, 0);  // boot cycle 1
    addv(0,1,0,0,0, 7'b0011000, 0);  // boot cycle 2
    addv(0,1,0,0,0, 7'b1110000, 0);  // streaming
    addv(0,1,0,0,0, 7'b1110000, 0);
    addv(0,0,0,0,0, 7'b1011000, 0);  // miss: bubble
    addv(0,0,0,0,0, 7'b1011000, 1);
    addv(0,0,0,0,0, 7'b1011000, 2);
    addv(0,1,0,0,0, 7'b1110000, 3);  // resume
    addv(0,1,0,1,0, 7'b1111010, 3);  // branch
    addv(0,1,0,0,0, 7'b0011000, 3);  // abort cycle
    addv(0,1,0,0,0, 7'b1110000, 3);
    addv(0,1,1,1,1, 7'b1111100, 3);  // pcWrite beats branch and stall
    addv(0,1,1,1,1, 7'b0111100, 3);  // back-to-back redirect
    addv(0,1,0,0,0, 7'b0011000, 3);
    addv(0,1,0,0,0, 7'b1110000, 3);
    addv(0,1,0,0,1, 7'b1000000, 3);  // decode stall holds
    addv(0,1,0,0,1, 7'b1000000, 4);
    addv(0,1,0,0,0, 7'b1110000, 5);
    addv(0,0,0,0,0, 7'b1011000, 5);  // miss then branch while waiting
    addv(0,0,0,1,0, 7'b1111010, 6);
    addv(0,0,0,0,0, 7'b0011000, 6);
    addv(0,0,0,0,0, 7'b1011000, 6);
    addv(0,0,0,0,1, 7'b1000000, 7);  // stall during wait
    addv(0,1,0,0,1, 7'b1000000, 8);
    addv(0,1,0,0,0, 7'b1110000, 9);
    addv(1,1,0,0,0, 7'b1110000, 9);  // reset takes effect at the edge
    addv(0,1,1,1,0, 7'b0011000, 0);  // redirects ignored in boot
    addv(0,1,0,1,0, 7'b0011000, 0);
    addv(0,1,0,0,0, 7'b1110000, 0);

    drive(1, 0, 0, 0, 0);
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].pcw, tbl[i].br, tbl[i].stall);
      @(negedge clock);
      check($sformatf("tbl_out[%0d]", i), 32'(actVec()), 32'(tbl[i].exp));
      check($sformatf("tbl_cnt[%0d]", i), 32'(stallCount), 32'(tbl[i].cnt));
      check($sformatf("tbl_cnt3[%0d]", i), 32'(stallCount3), 32'(sat3(int'(tbl[i].cnt))));
      tick();
    end

    // memory timeout: fifteen misses are tolerated, then sticky error
    for (int i = 0; i < MAXW; i++) begin
      drive(0, 0, 0, 0, 0);
      @(negedge clock);
      check("t6_wait", 32'(actVec()), 32'(7'b1011000));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, 0);
      @(negedge clock);
      check("t6_err", 32'(actVec()), 32'(7'b0011001));
      tick();
    end
    drive(1, 1, 0, 0, 0);
    @(negedge clock);
    check("t6_err_rst", 32'(actVec()), 32'(7'b0011001));
    tick();
    drive(0, 1, 0, 0, 0);
    @(negedge clock);
    check("t6_boot", 32'(actVec()), 32'(7'b0011000));
    check("t6_cnt", 32'(stallCount), 32'd0);
    tick();

    // random traffic against the model, with occasional long miss bursts
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rd, pw, b;
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = 20;
      rd = (burst > 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
      pw = (burst > 0) ? 1'b0 : ($urandom_range(0, 11) == 0);
      b  = (burst > 0) ? 1'b0 : ($urandom_range(0, 7) == 0);
      if (burst > 0) burst--;
      drive($urandom_range(0, 99) == 0, rd, pw, b, $urandom_range(0, 5) == 0);
      @(negedge clock);
      modelEval();
      check("rnd_out", 32'(actVec()), 32'(mVec));
      check("rnd_out3", 32'(actVec3()), 32'(mVec));
      check("rnd_cnt", 32'(stallCount), 32'(mStalls));
      check("rnd_cnt3", 32'(stallCount3), 32'(sat3(mStalls)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
